// File: rtl/hwpe_ctrl_job_queue.sv
// Job queue controller: cores acquire a context slot, program it, then trigger; committed jobs run in FIFO order.
// Latency: register responses 1 cycle after request; trigger-to-start 2 cycles from idle; events 1 cycle after cause.
// Backpressure: none on the config port (grant tied high); ACQUIRE returns all-ones when no slot is free.
module hwpe_ctrl_job_queue #(
  parameter int N_CORES      = 4,
  parameter int N_CONTEXT    = 3,
  parameter int N_EVT        = 4,
  parameter int N_SW_EVT     = 8,
  parameter int JOB_ID_WIDTH = 8,
  parameter int CLEAR_CYCLES = 3,
  localparam int CTX_W = (N_CONTEXT > 1) ? $clog2(N_CONTEXT) : 1
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       cfg_req,
  output logic                       cfg_gnt,
  input  logic [31:0]                cfg_add,
  input  logic                       cfg_wen,
  input  logic [3:0]                 cfg_be,
  input  logic [31:0]                cfg_data,
  input  logic [N_CORES-1:0]         cfg_id,
  output logic [31:0]                cfg_r_data,
  output logic                       cfg_r_valid,
  output logic [N_CORES-1:0]         cfg_r_id,
  input  logic                       done_i,
  input  logic [N_EVT-2:0]           evt_i,
  output logic                       start_o,
  output logic                       busy_o,
  output logic [CTX_W-1:0]           ctx_ptr_o,
  output logic [CTX_W-1:0]           running_ctx_o,
  output logic [N_CORES*N_EVT-1:0]   evt_o,
  output logic [N_SW_EVT-1:0]        sw_evt_o,
  output logic                       clear_o
);

  localparam int PEND_W = $clog2(N_CONTEXT + 1);
  localparam int CLR_W  = $clog2(CLEAR_CYCLES + 1);
  localparam int SW_W   = (N_SW_EVT > 1) ? $clog2(N_SW_EVT) : 1;

  typedef enum logic [1:0] {ST_IDLE, ST_STARTING, ST_RUNNING} state_t;

  state_t                    state, state_n;
  logic [JOB_ID_WIDTH-1:0]   job_id;
  logic [JOB_ID_WIDTH-1:0]   slot_job   [N_CONTEXT];
  logic [N_CORES-1:0]        slot_owner [N_CONTEXT];
  logic [N_CORES-1:0]        owner;
  logic                      acq;
  logic [PEND_W-1:0]         pending;
  logic [31:0]               finished;
  logic [CLR_W-1:0]          clr_cnt;
  logic [31:0]               rd_mux;

  logic [2:0]                idx;
  logic                      wr_acc, is_owner, acq_ok, trig, cancel;
  logic                      clr_wr, sw_wr, clr_now, done_acc, full;
  logic [SW_W-1:0]           sw_idx;

  // Address bits outside the word index and the byte enables carry no meaning here.
  logic unused_bits;
  assign unused_bits = ^{cfg_add[31:5], cfg_add[1:0], cfg_be, cfg_data[31:SW_W]};

  assign cfg_gnt  = 1'b1;
  assign idx      = cfg_add[4:2];
  assign sw_idx   = cfg_data[SW_W-1:0];
  assign clear_o  = (clr_cnt != '0);
  assign full     = (pending == PEND_W'(N_CONTEXT));
  assign is_owner = (cfg_id == owner);
  // Writes are dropped while a soft clear is in progress.
  assign wr_acc   = cfg_req && !cfg_wen && !clear_o;
  assign acq_ok   = cfg_req && cfg_wen && (idx == 3'd1) && !acq &&
                    (pending < PEND_W'(N_CONTEXT)) && !clear_o;
  assign trig     = wr_acc && (idx == 3'd0) && acq && is_owner;
  assign cancel   = wr_acc && (idx == 3'd2) && acq && is_owner;
  assign clr_wr   = wr_acc && (idx == 3'd5);
  assign sw_wr    = wr_acc && (idx == 3'd6);
  // State is held at its reset value from the clearing write's edge until clear_o drops.
  assign clr_now  = clr_wr || clear_o;
  assign done_acc = (state == ST_RUNNING) && done_i && !clr_now;

  function automatic logic [CTX_W-1:0] ctx_inc(input logic [CTX_W-1:0] p);
    return (p == CTX_W'(N_CONTEXT - 1)) ? '0 : p + CTX_W'(1);
  endfunction

  // Run FSM state register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state <= ST_IDLE;
    else         state <= state_n;
  end

  // Run FSM next state and start/busy decode.
  always_comb begin
    state_n = state;
    start_o = 1'b0;
    busy_o  = 1'b0;
    case (state)
      ST_IDLE:     if (pending != '0) state_n = ST_STARTING;
      ST_STARTING: begin
        start_o = 1'b1;
        busy_o  = 1'b1;
        state_n = ST_RUNNING;
      end
      ST_RUNNING:  begin
        busy_o = 1'b1;
        if (done_i) state_n = ST_IDLE;
      end
      default:     state_n = ST_IDLE;
    endcase
    if (clr_now) state_n = ST_IDLE;
  end

  // Slot bookkeeping: acquisition, commit, cancel and queue pointers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni || clr_now) begin
      job_id        <= '0;
      owner         <= '0;
      acq           <= 1'b0;
      pending       <= '0;
      ctx_ptr_o     <= '0;
      running_ctx_o <= '0;
      for (int i = 0; i < N_CONTEXT; i++) begin
        slot_job[i]   <= '0;
        slot_owner[i] <= '0;
      end
    end else begin
      if (acq_ok) begin
        acq                   <= 1'b1;
        owner                 <= cfg_id;
        slot_job[ctx_ptr_o]   <= job_id;
        slot_owner[ctx_ptr_o] <= cfg_id;
        job_id                <= job_id + JOB_ID_WIDTH'(1);
      end
      if (trig || cancel) acq <= 1'b0;
      if (trig)           ctx_ptr_o <= ctx_inc(ctx_ptr_o);
      if (done_acc)       running_ctx_o <= ctx_inc(running_ctx_o);
      // A commit and a completion in the same cycle cancel out.
      if (trig && !done_acc)      pending <= pending + PEND_W'(1);
      else if (!trig && done_acc) pending <= pending - PEND_W'(1);
    end
  end

  // Completed-job counter survives soft clear and saturates.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)                          finished <= '0;
    else if (done_acc && finished != '1)  finished <= finished + 32'd1;
  end

  // Soft-clear length counter; a new request is only seen once the previous one has ended.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)             clr_cnt <= '0;
    else if (clr_wr)         clr_cnt <= CLR_W'(CLEAR_CYCLES);
    else if (clr_cnt != '0)  clr_cnt <= clr_cnt - CLR_W'(1);
  end

  // Per-core events routed to the owner of the running slot, plus one-hot software events.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      evt_o    <= '0;
      sw_evt_o <= '0;
    end else begin
      evt_o    <= '0;
      sw_evt_o <= '0;
      if (!clr_now) begin
        for (int c = 0; c < N_CORES; c++) begin
          if (slot_owner[running_ctx_o][c]) begin
            evt_o[c*N_EVT] <= done_acc;
            if (busy_o) evt_o[c*N_EVT+1 +: N_EVT-1] <= evt_i;
          end
        end
        // Out-of-range indices shift the bit off the top and produce no pulse.
        if (sw_wr) sw_evt_o <= N_SW_EVT'(1) << sw_idx;
      end
    end
  end

  // Read data selection, sampled in the request cycle.
  always_comb begin
    rd_mux = '0;
    case (idx)
      3'd1: rd_mux = acq_ok ? 32'(job_id) : 32'hFFFF_FFFF;
      3'd3: rd_mux = {8'(running_ctx_o), 8'(ctx_ptr_o), 5'd0, full, acq, busy_o, 8'(pending)};
      3'd4: rd_mux = busy_o ? 32'(slot_job[running_ctx_o]) : 32'd0;
      3'd7: rd_mux = finished;
      default: rd_mux = '0;
    endcase
  end

  // Registered response channel; writes answer with zero data.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cfg_r_valid <= 1'b0;
      cfg_r_id    <= '0;
      cfg_r_data  <= '0;
    end else begin
      cfg_r_valid <= cfg_req;
      cfg_r_id    <= cfg_req ? cfg_id : '0;
      cfg_r_data  <= (cfg_req && cfg_wen) ? rd_mux : 32'd0;
    end
  end

endmodule

// File: tb/tb_hwpe_ctrl_job_queue.sv
// Directed bench for the job queue: acquire/trigger/cancel, queue full, start timing, events, soft clear, reset.
// Latency: inputs driven on the falling edge, outputs sampled on the following falling edge.
// Backpressure: none; every config access completes in one cycle.
module tb_hwpe_ctrl_job_queue;

  localparam int N_CORES = 4;
  localparam int N_EVT   = 4;

  localparam logic [2:0] A_TRIG = 3'd0, A_ACQ = 3'd1, A_CANCEL = 3'd2, A_STATUS = 3'd3,
                         A_RUN  = 3'd4, A_CLR = 3'd5, A_SWEVT  = 3'd6, A_FIN    = 3'd7;
  localparam logic [3:0] C0 = 4'b0001, C1 = 4'b0010, C2 = 4'b0100;

  logic        clk_i, rst_ni;
  logic        cfg_req, cfg_gnt, cfg_wen, cfg_r_valid;
  logic [31:0] cfg_add, cfg_data, cfg_r_data;
  logic [3:0]  cfg_be;
  logic [N_CORES-1:0] cfg_id, cfg_r_id;
  logic        done_i, start_o, busy_o, clear_o;
  logic [N_EVT-2:0] evt_i;
  logic [1:0]  ctx_ptr_o, running_ctx_o;
  logic [N_CORES*N_EVT-1:0] evt_o;
  logic [7:0]  sw_evt_o;

  int n_checks = 0;
  int n_fail   = 0;

  hwpe_ctrl_job_queue dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .cfg_req(cfg_req), .cfg_gnt(cfg_gnt), .cfg_add(cfg_add), .cfg_wen(cfg_wen),
    .cfg_be(cfg_be), .cfg_data(cfg_data), .cfg_id(cfg_id),
    .cfg_r_data(cfg_r_data), .cfg_r_valid(cfg_r_valid), .cfg_r_id(cfg_r_id),
    .done_i(done_i), .evt_i(evt_i), .start_o(start_o), .busy_o(busy_o),
    .ctx_ptr_o(ctx_ptr_o), .running_ctx_o(running_ctx_o),
    .evt_o(evt_o), .sw_evt_o(sw_evt_o), .clear_o(clear_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk_i);
  endtask

  // One config access; called on a falling edge, returns on the next one with the response.
  task automatic bus(input logic wen, input logic [2:0] idx, input logic [31:0] data,
                     input logic [N_CORES-1:0] id, output logic [31:0] rdata);
    cfg_req  = 1'b1;
    cfg_wen  = wen;
    cfg_add  = {27'd0, idx, 2'b00};
    cfg_data = data;
    cfg_id   = id;
    @(negedge clk_i);
    check("r_valid", 32'(cfg_r_valid), 32'd1);
    check("r_id", 32'(cfg_r_id), 32'(id));
    rdata    = cfg_r_data;
    cfg_req  = 1'b0;
    cfg_wen  = 1'b0;
    cfg_add  = '0;
    cfg_data = '0;
    cfg_id   = '0;
  endtask

  task automatic rd(input string tag, input logic [2:0] idx, input logic [N_CORES-1:0] id,
                    input logic [31:0] exp);
    logic [31:0] r;
    bus(1'b1, idx, 32'd0, id, r);
    check(tag, r, exp);
  endtask

  task automatic wr(input logic [2:0] idx, input logic [31:0] data, input logic [N_CORES-1:0] id);
    logic [31:0] r;
    bus(1'b0, idx, data, id, r);
    check("wr_rdata", r, 32'd0);
  endtask

  task automatic do_reset();
    rst_ni = 1'b0;
    tick(2);
    rst_ni = 1'b1;
    tick(1);
  endtask

  initial begin
    rst_ni = 1'b0; cfg_req = 1'b0; cfg_wen = 1'b0; cfg_add = '0; cfg_be = 4'hF;
    cfg_data = '0; cfg_id = '0; done_i = 1'b0; evt_i = '0;
    tick(2);

    // Reset state
    check("rst_start", 32'(start_o), 0);
    check("rst_busy", 32'(busy_o), 0);
    check("rst_ctx_ptr", 32'(ctx_ptr_o), 0);
    check("rst_run_ctx", 32'(running_ctx_o), 0);
    check("rst_evt", 32'(evt_o), 0);
    check("rst_sw_evt", 32'(sw_evt_o), 0);
    check("rst_clear", 32'(clear_o), 0);
    check("rst_r_valid", 32'(cfg_r_valid), 0);
    check("gnt", 32'(cfg_gnt), 1);
    rst_ni = 1'b1;
    tick(1);

    // Single job: acquire, trigger, start at t+2, events, done
    rd("s1_acq", A_ACQ, C0, 32'd0);
    wr(A_TRIG, 32'd0, C0);
    check("s1_start_t1", 32'(start_o), 0);
    tick(1);
    check("s1_start_t2", 32'(start_o), 1);
    check("s1_busy_t2", 32'(busy_o), 1);
    tick(1);
    check("s1_start_t3", 32'(start_o), 0);
    check("s1_busy_t3", 32'(busy_o), 1);
    evt_i = 3'b101;
    tick(1);
    check("s1_evt_fwd", 32'(evt_o), 32'h000A);
    evt_i = '0;
    check("s1_r_valid_idle", 32'(cfg_r_valid), 0);
    rd("s1_running_job", A_RUN, C0, 32'd0);
    done_i = 1'b1;
    tick(1);
    done_i = 1'b0;
    check("s1_done_evt", 32'(evt_o), 32'h0001);
    check("s1_busy_done", 32'(busy_o), 0);
    tick(1);
    check("s1_done_evt_end", 32'(evt_o), 0);
    rd("s1_finished", A_FIN, C0, 32'd1);

    // Queue full, then one completion frees a slot
    do_reset();
    for (int k = 0; k < 3; k++) begin
      rd("s2_acq", A_ACQ, C0, 32'(k));
      wr(A_TRIG, 32'd0, C0);
    end
    rd("s2_status_full", A_STATUS, C0, 32'h0000_0503);
    rd("s2_acq_full", A_ACQ, C0, 32'hFFFF_FFFF);
    done_i = 1'b1;
    tick(1);
    done_i = 1'b0;
    rd("s2_status_after", A_STATUS, C0, 32'h0100_0002);
    rd("s2_acq_after", A_ACQ, C0, 32'd3);

    // Ownership: foreign trigger/cancel ignored, cancel consumes the job ID
    do_reset();
    rd("s3_acq0", A_ACQ, C0, 32'd0);
    wr(A_TRIG, 32'd0, C1);
    rd("s3_status_held", A_STATUS, C0, 32'h0000_0200);
    rd("s3_acq1_busy", A_ACQ, C1, 32'hFFFF_FFFF);
    wr(A_CANCEL, 32'd0, C1);
    rd("s3_status_fcancel", A_STATUS, C0, 32'h0000_0200);
    wr(A_CANCEL, 32'd0, C0);
    rd("s3_status_cancel", A_STATUS, C0, 32'h0000_0000);
    rd("s3_acq1", A_ACQ, C1, 32'd1);

    // Trigger and done in the same cycle
    do_reset();
    for (int k = 0; k < 2; k++) begin
      rd("s4_acq", A_ACQ, C0, 32'(k));
      wr(A_TRIG, 32'd0, C0);
    end
    tick(3);
    rd("s4_status_pre", A_STATUS, C0, 32'h0002_0102);
    rd("s4_acq3", A_ACQ, C0, 32'd2);
    done_i = 1'b1;
    wr(A_TRIG, 32'd0, C0);
    done_i = 1'b0;
    check("s4_ctx_ptr_wrap", 32'(ctx_ptr_o), 0);
    check("s4_run_ctx", 32'(running_ctx_o), 1);
    check("s4_done_evt", 32'(evt_o), 32'h0001);
    rd("s4_status_post", A_STATUS, C0, 32'h0100_0002);
    rd("s4_running_job", A_RUN, C0, 32'd1);

    // Software events and soft clear
    do_reset();
    wr(A_SWEVT, 32'd5, C0);
    check("s5_sw_evt", 32'(sw_evt_o), 32'h20);
    tick(1);
    check("s5_sw_evt_end", 32'(sw_evt_o), 0);
    rd("s5_acq", A_ACQ, C2, 32'd0);
    wr(A_TRIG, 32'd0, C2);
    tick(3);
    done_i = 1'b1;
    tick(1);
    done_i = 1'b0;
    check("s5_done_evt_c2", 32'(evt_o), 32'h0100);
    rd("s5_finished", A_FIN, C2, 32'd1);
    rd("s5_acq2", A_ACQ, C2, 32'd1);
    wr(A_TRIG, 32'd0, C2);
    tick(3);
    check("s5_busy_pre", 32'(busy_o), 1);
    done_i = 1'b1;
    wr(A_CLR, 32'd0, C2);
    done_i = 1'b0;
    check("s5_clear_c1", 32'(clear_o), 1);
    check("s5_busy_clr", 32'(busy_o), 0);
    check("s5_ctx_ptr_clr", 32'(ctx_ptr_o), 0);
    wr(A_CLR, 32'd0, C2);
    check("s5_clear_c2", 32'(clear_o), 1);
    check("s5_no_done_evt", 32'(evt_o), 0);
    tick(1);
    check("s5_clear_c3", 32'(clear_o), 1);
    tick(1);
    check("s5_clear_end", 32'(clear_o), 0);
    rd("s5_status_clr", A_STATUS, C0, 32'd0);
    rd("s5_finished_kept", A_FIN, C0, 32'd1);
    done_i = 1'b1;
    tick(1);
    done_i = 1'b0;
    check("s5_idle_done_evt", 32'(evt_o), 0);

    // Asynchronous reset while running
    rd("s6_acq", A_ACQ, C2, 32'd0);
    wr(A_TRIG, 32'd0, C2);
    tick(3);
    evt_i = 3'b111;
    tick(1);
    check("s6_evt_fwd_c2", 32'(evt_o), 32'h0E00);
    #1 rst_ni = 1'b0;
    #1;
    check("s6_rst_busy", 32'(busy_o), 0);
    check("s6_rst_evt", 32'(evt_o), 0);
    check("s6_rst_ctx_ptr", 32'(ctx_ptr_o), 0);
    check("s6_rst_start", 32'(start_o), 0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    done_i = 1'b1;
    tick(2);
    check("s6_evt_after", 32'(evt_o), 0);
    check("s6_busy_after", 32'(busy_o), 0);
    done_i = 1'b0;
    evt_i  = '0;
    rd("s6_finished", A_FIN, C0, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
